zeroheti_obi_arbiter: RTL and testbench

//  Shares one OBI subordinate port (for example, the SoC interconnect slot) among NumMgr OBI managers.

---
 rtl/zeroheti_obi_arbiter.sv | 153 +++++++++++++++
 tb/tb_zeroheti_obi_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/zeroheti_obi_arbiter.sv
// zeroheti_obi_arbiter: shares one OBI subordinate port among NumMgr managers.
// Round-robin choice, held while the address phase waits for a grant; an ID
// FIFO of granted managers steers each in-order response back to its issuer.
//
// Handshake: an address phase transfers on a cycle with req=1 and gnt=1; the
// manager keeps req and its address-phase signals stable until that cycle.
// Responses come back in order, one per cycle with rvalid=1 and no back-pressure.
module zeroheti_obi_arbiter #(
  parameter int unsigned NumMgr    = 2,
  parameter int unsigned MaxOutst  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumMgr-1:0]               mgr_req_i,
  output logic [NumMgr-1:0]               mgr_gnt_o,
  input  logic [NumMgr*AddrWidth-1:0]     mgr_addr_i,
  input  logic [NumMgr-1:0]               mgr_we_i,
  input  logic [NumMgr*(DataWidth/8)-1:0] mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]     mgr_wdata_i,
  output logic [NumMgr-1:0]               mgr_rvalid_o,
  output logic [DataWidth-1:0]            mgr_rdata_o,
  output logic [NumMgr-1:0]               mgr_err_o,
  output logic                            sbr_req_o,
  input  logic                            sbr_gnt_i,
  output logic [AddrWidth-1:0]            sbr_addr_o,
  output logic                            sbr_we_o,
  output logic [DataWidth/8-1:0]          sbr_be_o,
  output logic [DataWidth-1:0]            sbr_wdata_o,
  input  logic                            sbr_rvalid_i,
  input  logic [DataWidth-1:0]            sbr_rdata_i,
  input  logic                            sbr_err_i
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned SelW    = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned CntW    = $clog2(MaxOutst + 1);
  localparam int unsigned PtrW    = (MaxOutst > 1) ? $clog2(MaxOutst) : 1;

  // IDLE: selection follows the round-robin winner; HOLD: selection frozen in sel_q
  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SelW-1:0] fifo_q [MaxOutst];

  logic [SelW-1:0] winner;
  logic [SelW-1:0] scan_idx;
  logic [SelW-1:0] sel;
  logic [SelW-1:0] head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutst - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin winner: first requester starting at rr_ptr; lowest offset wins
  always_comb begin
    winner   = rr_ptr_q;
    scan_idx = '0;
    for (int i = int'(NumMgr) - 1; i >= 0; i--) begin
      scan_idx = SelW'((int'(rr_ptr_q) + i) % int'(NumMgr));
      if (mgr_req_i[scan_idx]) winner = scan_idx;
    end
  end

  // Address-phase path: selection, downstream request, mux and grant fan-out
  always_comb begin
    sel         = (state_q == ST_HOLD) ? sel_q : winner;
    full        = (cnt_q == CntW'(MaxOutst));
    empty       = (cnt_q == '0);
    // Full blocks the request regardless of a same-cycle rvalid, so gnt never
    // depends combinationally on rvalid.
    sbr_req_o   = mgr_req_i[sel] & ~full & ~rst_i;
    push        = sbr_req_o & sbr_gnt_i;
    sbr_addr_o  = mgr_addr_i[int'(sel) * int'(AddrWidth) +: AddrWidth];
    sbr_we_o    = mgr_we_i[sel];
    sbr_be_o    = mgr_be_i[int'(sel) * int'(BeWidth) +: BeWidth];
    sbr_wdata_o = mgr_wdata_i[int'(sel) * int'(DataWidth) +: DataWidth];
    mgr_gnt_o   = '0;
    if (push) mgr_gnt_o[sel] = 1'b1;
  end

  // Response path: route to the FIFO head; a response with nothing outstanding is dropped
  always_comb begin
    head         = fifo_q[rd_ptr_q];
    pop          = sbr_rvalid_i & ~empty & ~rst_i;
    mgr_rdata_o  = sbr_rdata_i;
    mgr_rvalid_o = '0;
    mgr_err_o    = '0;
    if (pop) begin
      mgr_rvalid_o[head] = 1'b1;
      mgr_err_o[head]    = sbr_err_i;
    end
  end

  // Next-state: lock on an ungranted request, release and advance rr_ptr on grant
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
    if (push) begin
      state_d  = ST_IDLE;
      rr_ptr_d = (sel == SelW'(NumMgr - 1)) ? '0 : sel + 1'b1;
    end else if (sbr_req_o && (state_q == ST_IDLE)) begin
      state_d = ST_HOLD;
      sel_d   = winner;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ID FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= sel;
  end

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(mgr_gnt_o));
  a_cnt_bound:   assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CntW'(MaxOutst));
  a_hold_addr:   assert property (@(posedge clk_i) disable iff (rst_i)
                                  (state_q == ST_HOLD) |-> $stable(sbr_addr_o));
  a_stray_rsp:   assert property (@(posedge clk_i) disable iff (rst_i) !(sbr_rvalid_i && empty))
    else $warning("response arrived with no outstanding transaction; dropped");

endmodule

// File: tb/tb_zeroheti_obi_arbiter.sv
// tb_zeroheti_obi_arbiter: random managers and a random downstream subordinate,
// checked against a transaction-level model of round-robin arbitration and
// in-order response routing.
module tb_zeroheti_obi_arbiter;

  localparam int N  = 2;
  localparam int MO = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic [N-1:0]    mgr_req_i, mgr_gnt_o, mgr_we_i, mgr_rvalid_o, mgr_err_o;
  logic [N*AW-1:0] mgr_addr_i;
  logic [N*BW-1:0] mgr_be_i;
  logic [N*DW-1:0] mgr_wdata_i;
  logic [DW-1:0]   mgr_rdata_o;
  logic            sbr_req_o, sbr_gnt_i, sbr_we_o, sbr_rvalid_i, sbr_err_i;
  logic [AW-1:0]   sbr_addr_o;
  logic [BW-1:0]   sbr_be_o;
  logic [DW-1:0]   sbr_wdata_o, sbr_rdata_i;

  zeroheti_obi_arbiter #(.NumMgr(N), .MaxOutst(MO), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
    .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
    .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o),
    .sbr_we_o(sbr_we_o), .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
    .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i)
  );

  // ---------------- reference model state ----------------
  logic [N-1:0]  mreq;
  logic [AW-1:0] maddr [N];
  logic          mwe   [N];
  logic [BW-1:0] mbe   [N];
  logic [DW-1:0] mwd   [N];
  int            rr;
  int            held;
  int            id_q[$];

  typedef struct packed {
    logic          req;
    logic [N-1:0]  gnt;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } cyc_t;

  typedef struct packed {
    logic [N-1:0]  vld;
    logic [N-1:0]  err;
    logic [DW-1:0] data;
  } rsp_t;

  cyc_t cyc_q[$];
  rsp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Manager that owns the downstream port this cycle, or -1 if nobody requests
  function automatic int pick();
    if (held >= 0) return held;
    for (int k = 0; k < N; k++) begin
      if (mreq[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic run_cycle(input int req_pct, input int gnt_pct, input int rv_pct,
                           input bit do_rst, input bit stray);
    int   sel;
    int   id;
    bit   full;
    cyc_t c;
    rsp_t r;
    rst_i = do_rst;
    full  = (id_q.size() >= MO);
    for (int m = 0; m < N; m++) begin
      if (!mreq[m] && !do_rst && (int'($urandom_range(99)) < req_pct)) begin
        mreq[m]  = 1'b1;
        maddr[m] = $urandom;
        mwe[m]   = 1'($urandom_range(1));
        mbe[m]   = BW'($urandom);
        mwd[m]   = $urandom;
      end
      mgr_req_i[m]             = mreq[m];
      mgr_addr_i[m*AW +: AW]   = maddr[m];
      mgr_we_i[m]              = mwe[m];
      mgr_be_i[m*BW +: BW]     = mbe[m];
      mgr_wdata_i[m*DW +: DW]  = mwd[m];
    end
    sbr_gnt_i    = (int'($urandom_range(99)) < gnt_pct);
    sbr_rdata_i  = $urandom;
    sbr_err_i    = 1'($urandom_range(1));
    sbr_rvalid_i = 1'b0;
    if (do_rst) begin
      sbr_rvalid_i = 1'($urandom_range(1));
    end else if (stray || (id_q.size() > 0 && int'($urandom_range(99)) < rv_pct)) begin
      sbr_rvalid_i = 1'b1;
      if (id_q.size() > 0) begin
        id          = id_q.pop_front();
        r.vld       = '0;
        r.vld[id]   = 1'b1;
        r.err       = sbr_err_i ? r.vld : '0;
        r.data      = sbr_rdata_i;
        exp_q.push_back(r);
      end
    end
    sel     = pick();
    c       = '0;
    c.req   = !do_rst && (sel >= 0) && !full;
    if (sel >= 0) begin
      c.addr  = maddr[sel];
      c.we    = mwe[sel];
      c.be    = mbe[sel];
      c.wdata = mwd[sel];
      if (c.req && sbr_gnt_i) c.gnt[sel] = 1'b1;
    end
    cyc_q.push_back(c);
    if (do_rst) begin
      rr   = 0;
      held = -1;
      id_q.delete();
      mreq = '0;
    end else if (c.req && sbr_gnt_i) begin
      id_q.push_back(sel);
      rr        = (sel + 1) % N;
      held      = -1;
      mreq[sel] = 1'b0;
    end else if (c.req) begin
      held = sel;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_phase(input int cycles, input int req_pct, input int gnt_pct, input int rv_pct);
    for (int i = 0; i < cycles; i++) run_cycle(req_pct, gnt_pct, rv_pct, 1'b0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  cyc_t mon_c;
  rsp_t mon_r;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_c = cyc_q.pop_front();
      check("sbr_req", 64'(sbr_req_o), 64'(mon_c.req));
      check("mgr_gnt", 64'(mgr_gnt_o), 64'(mon_c.gnt));
      if (mon_c.req) begin
        check("sbr_addr",  64'(sbr_addr_o),  64'(mon_c.addr));
        check("sbr_we",    64'(sbr_we_o),    64'(mon_c.we));
        check("sbr_be",    64'(sbr_be_o),    64'(mon_c.be));
        check("sbr_wdata", 64'(sbr_wdata_o), 64'(mon_c.wdata));
      end
    end
    if (|mgr_rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_rvalid", 64'(mgr_rvalid_o), 64'(0));
      end else begin
        mon_r = exp_q.pop_front();
        check("mgr_rvalid", 64'(mgr_rvalid_o), 64'(mon_r.vld));
        check("mgr_err",    64'(mgr_err_o),    64'(mon_r.err));
        check("mgr_rdata",  64'(mgr_rdata_o),  64'(mon_r.data));
      end
    end
  end

  // ---------------- stimulus sequence and report ----------------
  initial begin
    rst_i        = 1'b1;
    mgr_req_i    = '0;
    mgr_addr_i   = '0;
    mgr_we_i     = '0;
    mgr_be_i     = '0;
    mgr_wdata_i  = '0;
    sbr_gnt_i    = 1'b0;
    sbr_rvalid_i = 1'b0;
    sbr_rdata_i  = '0;
    sbr_err_i    = 1'b0;
    mreq         = '0;
    rr           = 0;
    held         = -1;
    for (int m = 0; m < N; m++) begin
      maddr[m] = '0;
      mwe[m]   = 1'b0;
      mbe[m]   = '0;
      mwd[m]   = '0;
    end
    @(posedge clk);
    #1;
    run_cycle(0, 0, 0, 1'b1, 1'b0);
    run_cycle(100, 100, 0, 1'b1, 1'b0);
    // both managers busy, always granted, responses one cycle later
    run_phase(16, 100, 100, 100);
    // slow grants: selection held across ungranted cycles
    run_phase(12, 100, 25, 100);
    // no responses: outstanding limit stops the request
    run_phase(8, 100, 100, 0);
    run_phase(300, 60, 50, 50);
    // reset with transactions outstanding, then a stray response
    run_phase(6, 100, 100, 0);
    run_cycle(100, 100, 0, 1'b1, 1'b0);
    run_cycle(0, 100, 0, 1'b0, 1'b1);
    run_phase(4, 100, 100, 100);
    run_phase(300, 70, 70, 40);
    run_phase(10, 0, 100, 100);
    @(negedge clk);
    #1;
    check("responses_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
